cnt_sched: RTL and testbench

- Two-requester round-robin scheduler for the shared seconds-counter datapath (inputs Slt, En; outputs Output0/Output1).
- Grants the counter to one requester at a time and drives Slt to pick the channel.
- Holds En high for exactly the number of enabled cycles the requested increment count needs.
- Signals completion per requester with a one-cycle Done pulse.
- Sits between the control logic and the counter; it is the only driver of the counter's Slt/En.

---
 rtl/cnt_sched.sv | 152 +++++++++++++++
 tb/tb_cnt_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cnt_sched.sv
// Two-requester round-robin scheduler driving the shared seconds-counter Slt/En.
// Define CNT_SCHED_STATS_EN to add the EnCycles/Grants0/Grants1 statistics outputs.
module cnt_sched #(
  parameter int LEN_W = 8,
  parameter int DIV1  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [LEN_W-1:0] Len0,
  input  logic             Req1,
  input  logic [LEN_W-1:0] Len1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Done0,
  output logic             Done1,
  output logic             Slt,
  output logic             En,
`ifdef CNT_SCHED_STATS_EN
  output logic [31:0]      EnCycles,
  output logic [15:0]      Grants0,
  output logic [15:0]      Grants1,
`endif
  output logic             Busy
);

  localparam int SH = $clog2(DIV1);
  localparam int CW = LEN_W + SH;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t        state, stateNext;
  logic          owner, ownerNext;
  logic          lastServed, lastServedNext;
  logic [CW-1:0] cnt, cntNext;
  logic          gnt0Next, gnt1Next, doneNext, sltNext, enNext, busyNext;
  logic          ownerReq, pick;

  assign ownerReq = owner ? Req1 : Req0;
  // With both requesting, the one not served last wins; otherwise whoever asks.
  assign pick     = (Req0 && Req1) ? ~lastServed : Req1;

  always_comb begin
    stateNext      = state;
    ownerNext      = owner;
    lastServedNext = lastServed;
    cntNext        = cnt;
    gnt0Next       = 1'b0;
    gnt1Next       = 1'b0;
    doneNext       = 1'b0;
    sltNext        = 1'b0;
    enNext         = 1'b0;
    busyNext       = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          stateNext = SETUP;
          ownerNext = pick;
          cntNext   = pick ? (CW'(Len1) << SH) : CW'(Len0);
          gnt0Next  = ~pick;
          gnt1Next  = pick;
          sltNext   = pick;
          busyNext  = 1'b1;
        end
      end
      SETUP: begin
        if (!ownerReq) begin
          stateNext = IDLE;
        end else begin
          gnt0Next = ~owner;
          gnt1Next = owner;
          sltNext  = owner;
          busyNext = 1'b1;
          if (cnt == '0) begin
            stateNext = DONE;
            doneNext  = 1'b1;
          end else begin
            stateNext = RUN;
            enNext    = 1'b1;
          end
        end
      end
      RUN: begin
        if (!ownerReq) begin
          stateNext = IDLE;
        end else begin
          gnt0Next = ~owner;
          gnt1Next = owner;
          sltNext  = owner;
          busyNext = 1'b1;
          cntNext  = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            stateNext = DONE;
            doneNext  = 1'b1;
          end else begin
            enNext = 1'b1;
          end
        end
      end
      DONE: begin
        stateNext      = IDLE;
        lastServedNext = owner;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Reset leaves lastServed at 1 so the first contention goes to requester 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lastServed <= 1'b1;
      cnt        <= '0;
      Gnt0       <= 1'b0;
      Gnt1       <= 1'b0;
      Done0      <= 1'b0;
      Done1      <= 1'b0;
      Slt        <= 1'b0;
      En         <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      owner      <= ownerNext;
      lastServed <= lastServedNext;
      cnt        <= cntNext;
      Gnt0       <= gnt0Next;
      Gnt1       <= gnt1Next;
      Done0      <= doneNext & ~ownerNext;
      Done1      <= doneNext & ownerNext;
      Slt        <= sltNext;
      En         <= enNext;
      Busy       <= busyNext;
    end
  end

`ifdef CNT_SCHED_STATS_EN
  // Statistics count registered En cycles and Done pulses; all wrap naturally.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      EnCycles <= '0;
      Grants0  <= '0;
      Grants1  <= '0;
    end else begin
      if (En)    EnCycles <= EnCycles + 32'd1;
      if (Done0) Grants0  <= Grants0 + 16'd1;
      if (Done1) Grants1  <= Grants1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched: directed scenarios plus randomized requesters
// checked every cycle against a grant-timeline reference model.
module tb_cnt_sched;
  localparam int LEN_W = 8;
  localparam int DIV1  = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Req0, Req1;
  logic [LEN_W-1:0] Len0, Len1;
  logic             Gnt0, Gnt1, Done0, Done1, Slt, En, Busy;
`ifdef CNT_SCHED_STATS_EN
  logic [31:0]      EnCycles;
  logic [15:0]      Grants0, Grants1;
`endif

  cnt_sched #(.LEN_W(LEN_W), .DIV1(DIV1)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Len0(Len0), .Req1(Req1), .Len1(Len1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Slt(Slt), .En(En),
`ifdef CNT_SCHED_STATS_EN
    .EnCycles(EnCycles), .Grants0(Grants0), .Grants1(Grants1),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: a grant accepted at edge g with target t owns the counter for t+2 cycles
  // after that edge (SETUP, t enabled cycles, DONE), then the block is idle again.
  bit          active;
  int          g, tgt, own, lastServed, cyc;
  logic [6:0]  expVec;
  logic [31:0] enCount;
  logic [15:0] grants0, grants1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelEdge(input bit rst);
    int  d;
    bit  ownReq, en, done;
    cyc++;
    if (rst) begin
      active     = 1'b0;
      lastServed = 1;
      enCount    = '0;
      grants0    = '0;
      grants1    = '0;
    end else begin
      if (expVec[1]) enCount = enCount + 32'd1;
      if (expVec[4]) grants0 = grants0 + 16'd1;
      if (expVec[3]) grants1 = grants1 + 16'd1;
      if (active) begin
        d      = cyc - g;
        ownReq = (own == 1) ? Req1 : Req0;
        if (d <= tgt + 1 && !ownReq) begin
          active = 1'b0;
        end else if (d == tgt + 2) begin
          active     = 1'b0;
          lastServed = own;
        end
      end else if (Req0 || Req1) begin
        own    = (Req0 && Req1) ? 1 - lastServed : (Req1 ? 1 : 0);
        tgt    = (own == 1) ? int'(Len1) * DIV1 : int'(Len0);
        g      = cyc;
        active = 1'b1;
      end
    end
    d      = cyc - g;
    en     = active && d >= 1 && d <= tgt;
    done   = active && d == tgt + 1;
    expVec = {active && own == 0, active && own == 1, done && own == 0, done && own == 1,
              active && own == 1, en, active};
  endtask

  task automatic applyStimulus(input bit rst);
    Reset = rst;
    modelEdge(rst);
    @(posedge Clk);
    #1;
    checkOutput("gnt0,gnt1,done0,done1,slt,en,busy",
                32'({Gnt0, Gnt1, Done0, Done1, Slt, En, Busy}), 32'(expVec));
`ifdef CNT_SCHED_STATS_EN
    checkOutput("enCycles", EnCycles, enCount);
    checkOutput("grants0", 32'(Grants0), 32'(grants0));
    checkOutput("grants1", 32'(Grants1), 32'(grants1));
`endif
  endtask

  task automatic runUntilDone(input bit who, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      applyStimulus(1'b0);
      seen = who ? Done1 : Done0;
    end
    checkOutput(who ? "done1Seen" : "done0Seen", 32'(seen), 32'd1);
  endtask

  function automatic logic [LEN_W-1:0] randLen();
    if ($urandom_range(9) == 0) return '0;
    return LEN_W'($urandom_range(12));
  endfunction

  initial begin
    int enSeen;
    cyc = 0; active = 1'b0; g = 0; tgt = 0; own = 0; lastServed = 1;
    expVec = '0; enCount = '0; grants0 = '0; grants1 = '0;
    Req0 = 1'b0; Req1 = 1'b0; Len0 = '0; Len1 = '0; Reset = 1'b1;

    repeat (3) applyStimulus(1'b1);

    // Channel 0, five increments
    Req0 = 1'b1; Len0 = 8'd5;
    runUntilDone(1'b0, 40);
    Req0 = 1'b0; applyStimulus(1'b0);

    // Channel 1, three increments -> twelve enabled cycles
    Req1 = 1'b1; Len1 = 8'd3;
    runUntilDone(1'b1, 40);
    Req1 = 1'b0; applyStimulus(1'b0);

    // Contention from reset: both held, grants alternate 0,1,0,1
    applyStimulus(1'b1);
    Req0 = 1'b1; Len0 = 8'd2; Req1 = 1'b1; Len1 = 8'd2;
    repeat (40) applyStimulus(1'b0);
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (15) applyStimulus(1'b0);

    // Zero-length request
    Req0 = 1'b1; Len0 = 8'd0;
    runUntilDone(1'b0, 10);
    Req0 = 1'b0; applyStimulus(1'b0);

    // Withdrawal after four enabled cycles; pointer must stay favouring 1
    Req1 = 1'b1; Len1 = 8'd10; enSeen = 0;
    for (int i = 0; i < 20 && enSeen < 4; i++) begin
      applyStimulus(1'b0);
      if (En) enSeen++;
    end
    checkOutput("enBeforeWithdraw", 32'(enSeen), 32'd4);
    Req1 = 1'b0;
    repeat (2) applyStimulus(1'b0);
    Req0 = 1'b1; Len0 = 8'd1; Req1 = 1'b1; Len1 = 8'd1;
    applyStimulus(1'b0);
    checkOutput("ptrKeptGnt1", 32'(Gnt1), 32'd1);
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (10) applyStimulus(1'b0);

    // Maximum target on channel 1
    Req1 = 1'b1; Len1 = 8'hff;
    runUntilDone(1'b1, 1100);
    Req1 = 1'b0; applyStimulus(1'b0);

    // Reset mid-run
    Req0 = 1'b1; Len0 = 8'd200;
    repeat (30) applyStimulus(1'b0);
    Req0 = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);

    // Randomized requesters, including withdrawals, Len churn and rare resets
    for (int n = 0; n < 4000; n++) begin
      if (!Req0) begin
        if ($urandom_range(9) < 3) begin Req0 = 1'b1; Len0 = randLen(); end
      end else if (Done0) begin
        if ($urandom_range(1) == 0) Req0 = 1'b0;
      end else if (Gnt0 && $urandom_range(99) < 2) begin
        Req0 = 1'b0;
      end
      if (!Req1) begin
        if ($urandom_range(9) < 3) begin Req1 = 1'b1; Len1 = randLen(); end
      end else if (Done1) begin
        if ($urandom_range(1) == 0) Req1 = 1'b0;
      end else if (Gnt1 && $urandom_range(99) < 2) begin
        Req1 = 1'b0;
      end
      if ($urandom_range(9) == 0) Len0 = randLen();
      if ($urandom_range(9) == 0) Len1 = randLen();
      applyStimulus($urandom_range(999) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
